// File: rtl/hermes_local_sink.sv
// HermesNoC local-port traffic sink: credit-controlled flit intake,
// packet parsing/checking and per-packet latency/statistics report.
module hermes_local_sink #(
   parameter int X_ADDR    = 0,
   parameter int Y_ADDR    = 0,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_i,
   input  logic [31:0]          data_i,
   output logic                 credit_o,
   input  logic                 stall_i,
   input  logic [31:0]          time_i,
   output logic                 pkt_valid_o,
   output logic [15:0]          pkt_src_o,
   output logic [31:0]          pkt_size_o,
   output logic [31:0]          pkt_num_o,
   output logic [31:0]          pkt_latency_o,
   output logic                 err_dest_o,
   output logic                 err_payload_o,
   output logic                 err_size_o,
   output logic [CNT_WIDTH-1:0] pkt_count_o,
   output logic [CNT_WIDTH-1:0] err_count_o
);

   typedef enum logic [2:0] {
      S_HEADER,
      S_SIZE,
      S_TSTAMP,
      S_PKTNUM,
      S_PAYLOAD
   } state_t;

   state_t state, state_nx;

   logic        acc;
   logic        tail;
   logic        pay_mis;
   logic        fin_pay;
   logic        fin_size_err;
   logic        fin_any_err;
   logic [31:0] fin_size;
   logic [31:0] fin_num;
   logic [31:0] fin_lat;

   logic [31:0] idx;
   logic [31:0] size_r;
   logic [31:0] num_r;
   logic [31:0] lat_r;
   logic [15:0] src_r;
   logic        dest_err_r;
   logic        pay_err_r;

   assign acc = rx_i && credit_o;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_HEADER;
      else        state <= state_nx;
   end

   // fin_* carry this cycle's flit so a tail flit reports its own data
   always_comb begin
      state_nx = state;
      tail     = 1'b0;
      pay_mis  = 1'b0;
      fin_size = size_r;
      fin_num  = num_r;
      fin_lat  = lat_r;
      unique case (state)
         S_HEADER: begin
            if (acc) state_nx = S_SIZE;
         end
         S_SIZE: begin
            fin_size = data_i;
            if (acc) begin
               if (data_i == 32'd0) begin
                  tail     = 1'b1;
                  state_nx = S_HEADER;
               end else begin
                  state_nx = S_TSTAMP;
               end
            end
         end
         S_TSTAMP: begin
            fin_lat = time_i - data_i;
            if (acc) begin
               if (size_r == 32'd1) begin
                  tail     = 1'b1;
                  state_nx = S_HEADER;
               end else begin
                  state_nx = S_PKTNUM;
               end
            end
         end
         S_PKTNUM: begin
            fin_num = data_i;
            if (acc) begin
               if (size_r == 32'd2) begin
                  tail     = 1'b1;
                  state_nx = S_HEADER;
               end else begin
                  state_nx = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            pay_mis = (data_i != idx - 32'd1);
            if (acc && idx == size_r + 32'd1) begin
               tail     = 1'b1;
               state_nx = S_HEADER;
            end
         end
         default: state_nx = S_HEADER;
      endcase
   end

   assign fin_pay      = pay_err_r | (acc & pay_mis);
   assign fin_size_err = (fin_size < 32'd2);
   assign fin_any_err  = dest_err_r | fin_pay | fin_size_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         credit_o      <= 1'b0;
         pkt_valid_o   <= 1'b0;
         pkt_src_o     <= '0;
         pkt_size_o    <= '0;
         pkt_num_o     <= '0;
         pkt_latency_o <= '0;
         err_dest_o    <= 1'b0;
         err_payload_o <= 1'b0;
         err_size_o    <= 1'b0;
         pkt_count_o   <= '0;
         err_count_o   <= '0;
         idx           <= '0;
         size_r        <= '0;
         num_r         <= '0;
         lat_r         <= '0;
         src_r         <= '0;
         dest_err_r    <= 1'b0;
         pay_err_r     <= 1'b0;
      end else begin
         credit_o    <= ~stall_i;
         pkt_valid_o <= tail;
         if (acc) begin
            idx <= idx + 32'd1;
            case (state)
               S_HEADER: begin
                  idx        <= 32'd1;
                  src_r      <= data_i[31:16];
                  dest_err_r <= (data_i[15:8] != 8'(X_ADDR))
                              || (data_i[7:0] != 8'(Y_ADDR));
                  pay_err_r  <= 1'b0;
                  size_r     <= '0;
                  num_r      <= '0;
                  lat_r      <= '0;
               end
               S_SIZE:    size_r    <= data_i;
               S_TSTAMP:  lat_r     <= fin_lat;
               S_PKTNUM:  num_r     <= data_i;
               S_PAYLOAD: pay_err_r <= fin_pay;
               default: ;
            endcase
         end
         if (tail) begin
            idx           <= '0;
            pkt_src_o     <= src_r;
            pkt_size_o    <= fin_size;
            pkt_num_o     <= fin_num;
            pkt_latency_o <= fin_lat;
            err_dest_o    <= dest_err_r;
            err_payload_o <= fin_pay;
            err_size_o    <= fin_size_err;
            if (!(&pkt_count_o))
               pkt_count_o <= pkt_count_o + CNT_WIDTH'(1);
            if (fin_any_err && !(&err_count_o))
               err_count_o <= err_count_o + CNT_WIDTH'(1);
         end
      end
   end

endmodule
